// File: rtl/snitch_pkg.sv
// Shared Snitch data-port types: request/response beats and the meta id tag.
package snitch_pkg;

  localparam int unsigned NumIntOutstandingLoads = 8;
  localparam int unsigned MetaIdWidth            = 4;
  localparam int unsigned AddrWidth              = 32;
  localparam int unsigned DataWidth              = 32;

  typedef logic [MetaIdWidth-1:0] meta_id_t;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    meta_id_t               id;
    logic                   write;
    logic [3:0]             amo;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
  } dreq_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    meta_id_t             id;
    logic                 write;
    logic                 error;
  } dresp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snitch_dresp_rob.sv
// In-order response reorder buffer: tags requests with a slot index and returns
// out-of-order memory responses to the core in issue order with the core id restored.
module snitch_dresp_rob import snitch_pkg::*; #(
  parameter int unsigned NumEntries  = NumIntOutstandingLoads,
  parameter int unsigned MetaIdWidth = idx_width(NumEntries)
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  dreq_t  core_req_i,
  input  logic   core_req_valid_i,
  output logic   core_req_ready_o,
  output dreq_t  mem_req_o,
  output logic   mem_req_valid_o,
  input  logic   mem_req_ready_i,
  input  dresp_t mem_resp_i,
  input  logic   mem_resp_valid_i,
  output logic   mem_resp_ready_o,
  output dresp_t core_resp_o,
  output logic   core_resp_valid_o,
  input  logic   core_resp_ready_i
);

  typedef logic [MetaIdWidth-1:0]             slot_t;
  typedef logic [$clog2(NumEntries+1)-1:0]    cnt_t;

  typedef struct packed {
    logic                 alloc;
    logic                 done;
    meta_id_t             core_id;
    logic [DataWidth-1:0] data;
    logic                 write;
    logic                 error;
  } rob_entry_t;

  localparam slot_t LastSlot = slot_t'(NumEntries - 1);
  localparam cnt_t  Capacity = cnt_t'(NumEntries);

  rob_entry_t entry_q [NumEntries];
  rob_entry_t entry_d [NumEntries];
  slot_t      head_q, head_d, tail_q, tail_d;
  cnt_t       cnt_q, cnt_d;

  logic  full, issue_fire, retire_fire, resp_in_range, resp_hit;
  slot_t resp_idx;

  // Explicit wrap so non-power-of-two depths work.
  function automatic slot_t bump(input slot_t p);
    return (p == LastSlot) ? '0 : p + slot_t'(1);
  endfunction

  // Issue: full looks only at the registered count.
  assign full             = (cnt_q == Capacity);
  assign core_req_ready_o = mem_req_ready_i & ~full;
  assign mem_req_valid_o  = core_req_valid_i & ~full;
  assign issue_fire       = core_req_valid_i & core_req_ready_o;

  always_comb begin
    mem_req_o    = core_req_i;
    mem_req_o.id = meta_id_t'(tail_q);
  end

  // Response capture: ids outside the slot range or on free slots are dropped.
  assign mem_resp_ready_o = 1'b1;
  assign resp_idx         = mem_resp_i.id[MetaIdWidth-1:0];
  assign resp_in_range    = (meta_id_t'(resp_idx) == mem_resp_i.id) &&
                            (32'(resp_idx) < NumEntries);
  assign resp_hit         = mem_resp_valid_i & resp_in_range & entry_q[resp_idx].alloc;

  // Retire straight from registered state; no mem_resp -> core_resp path.
  assign core_resp_valid_o = entry_q[head_q].alloc & entry_q[head_q].done;
  assign retire_fire       = core_resp_valid_o & core_resp_ready_i;

  always_comb begin
    core_resp_o.data  = entry_q[head_q].data;
    core_resp_o.id    = entry_q[head_q].core_id;
    core_resp_o.write = entry_q[head_q].write;
    core_resp_o.error = entry_q[head_q].error;
  end

  always_comb begin
    entry_d = entry_q;
    if (issue_fire) begin
      entry_d[tail_q].alloc   = 1'b1;
      entry_d[tail_q].done    = 1'b0;
      entry_d[tail_q].core_id = core_req_i.id;
    end
    if (resp_hit) begin
      entry_d[resp_idx].done  = 1'b1;
      entry_d[resp_idx].data  = mem_resp_i.data;
      entry_d[resp_idx].write = mem_resp_i.write;
      entry_d[resp_idx].error = mem_resp_i.error;
    end
    if (retire_fire) begin
      entry_d[head_q].alloc = 1'b0;
      entry_d[head_q].done  = 1'b0;
    end
  end

  always_comb begin
    head_d = retire_fire ? bump(head_q) : head_q;
    tail_d = issue_fire ? bump(tail_q) : tail_q;
    unique case ({issue_fire, retire_fire})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
    // Payload is don't-care while alloc is clear, so only the flags reset.
    for (int unsigned i = 0; i < NumEntries; i++) begin
      entry_q[i] <= entry_d[i];
      if (rst_i) begin
        entry_q[i].alloc <= 1'b0;
        entry_q[i].done  <= 1'b0;
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && mem_resp_valid_i) begin
      assert (resp_hit)
        else $warning("dresp_rob: response to non-allocated slot %0d dropped", mem_resp_i.id);
      assert (!(resp_hit && entry_q[resp_idx].done))
        else $error("dresp_rob: response to slot %0d which is already done", resp_idx);
    end
  end

endmodule

// File: tb/tb_snitch_dresp_rob.sv
// Scoreboard bench for snitch_dresp_rob: directed issue/response sequences with a
// queue of expected in-order responses checked by an independent monitor.
module tb_snitch_dresp_rob;
  import snitch_pkg::*;

  localparam int unsigned N = 5;

  logic   clk = 1'b0;
  logic   rst;
  dreq_t  core_req, mem_req;
  logic   core_req_valid, core_req_ready, mem_req_valid, mem_req_ready;
  dresp_t mem_resp, core_resp;
  logic   mem_resp_valid, mem_resp_ready, core_resp_valid, core_resp_ready;

  int     n_checks = 0;
  int     n_errors = 0;
  dresp_t exp_q[$];
  int     pend_q[$];
  int     exp_tail = 0;
  int     n_issued = 0;
  int     ret_cnt  = 0;
  int     seq      = 0;
  logic [31:0] sd [N];
  logic        sw [N];
  logic        se [N];
  dresp_t      mon_e;

  always #5 clk = ~clk;

  snitch_dresp_rob #(.NumEntries(N)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .core_req_i        (core_req),
    .core_req_valid_i  (core_req_valid),
    .core_req_ready_o  (core_req_ready),
    .mem_req_o         (mem_req),
    .mem_req_valid_o   (mem_req_valid),
    .mem_req_ready_i   (mem_req_ready),
    .mem_resp_i        (mem_resp),
    .mem_resp_valid_i  (mem_resp_valid),
    .mem_resp_ready_o  (mem_resp_ready),
    .core_resp_o       (core_resp),
    .core_resp_valid_o (core_resp_valid),
    .core_resp_ready_i (core_resp_ready)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input meta_id_t id, input logic wr);
    core_req       = '0;
    core_req.id    = id;
    core_req.write = wr;
    core_req.addr  = 32'h1000 + 32'(seq) * 4;
    core_req.data  = 32'hBEEF_0000 + 32'(seq);
    core_req.strb  = 4'hF;
  endtask

  // Called at a negedge while the current request is being accepted.
  task automatic accept_record(input string tag);
    dresp_t e;
    chk({tag, "_slot"}, 64'(mem_req.id), 64'(exp_tail));
    chk({tag, "_mvalid"}, 64'(mem_req_valid), 64'(1));
    chk({tag, "_addr"}, 64'(mem_req.addr), 64'(core_req.addr));
    sd[exp_tail] = {8'hD0, 8'(seq), 4'h0, core_req.id, 8'h5A};
    sw[exp_tail] = core_req.write;
    se[exp_tail] = (seq % 3 == 2);
    e.data  = sd[exp_tail];
    e.id    = core_req.id;
    e.write = sw[exp_tail];
    e.error = se[exp_tail];
    exp_q.push_back(e);
    pend_q.push_back(exp_tail);
    exp_tail = (exp_tail == N - 1) ? 0 : exp_tail + 1;
    seq++;
    n_issued++;
  endtask

  task automatic issue(input meta_id_t id, input logic wr, output int slot);
    int k = 0;
    set_req(id, wr);
    core_req_valid = 1'b1;
    @(negedge clk);
    while (!core_req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    slot = exp_tail;
    if (core_req_ready) accept_record("issue");
    else chk("issue_timeout", 64'(core_req_ready), 64'(1));
    step();
    core_req_valid = 1'b0;
  endtask

  task automatic respond(input int slot);
    int idx = -1;
    mem_resp.id    = meta_id_t'(slot);
    mem_resp.data  = sd[slot];
    mem_resp.write = sw[slot];
    mem_resp.error = se[slot];
    mem_resp_valid = 1'b1;
    for (int i = 0; i < pend_q.size(); i++) if (pend_q[i] == slot) idx = i;
    if (idx >= 0) pend_q.delete(idx);
    step();
    mem_resp_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (ret_cnt != n_issued && k < 100) begin
      step();
      k++;
    end
    chk({tag, "_drain"}, 64'(ret_cnt), 64'(n_issued));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: every retiring beat must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && core_resp_valid && core_resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mon_unexpected: got %0h expected no response", core_resp);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_resp", 64'(core_resp), 64'(mon_e));
        ret_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s[4];
    int sl;
    int guard;
    int r0;
    rst = 1'b1;
    core_req = '0;
    core_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_resp = '0;
    mem_resp_valid = 1'b0;
    core_resp_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", 64'(core_resp_valid), 64'(0));
    chk("rst_req_ready", 64'(core_req_ready), 64'(1));
    chk("rst_mvalid", 64'(mem_req_valid), 64'(0));
    chk("rst_mresp_ready", 64'(mem_resp_ready), 64'(1));
    step();
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_ready_follow", 64'(core_req_ready), 64'(0));
    step();
    mem_req_ready = 1'b1;

    // 1: in order, one cycle from mem response to core response
    issue(4'd5, 1'b0, s[0]);
    issue(4'd6, 1'b0, s[1]);
    issue(4'd7, 1'b1, s[2]);
    for (int i = 0; i < 3; i++) begin
      mem_resp.id    = meta_id_t'(s[i]);
      mem_resp.data  = sd[s[i]];
      mem_resp.write = sw[s[i]];
      mem_resp.error = se[s[i]];
      mem_resp_valid = 1'b1;
      pend_q.delete(0);
      @(negedge clk);
      chk("t1_no_comb", 64'(core_resp_valid), 64'(0));
      step();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      chk("t1_next_cycle", 64'(core_resp_valid), 64'(1));
      step();
    end

    // 2: reverse responses, nothing retires until the oldest returns
    for (int i = 0; i < 4; i++) issue(meta_id_t'(8 + i), 1'b0, s[i]);
    for (int i = 3; i >= 1; i--) begin
      respond(s[i]);
      @(negedge clk);
      chk("t2_hold", 64'(core_resp_valid), 64'(0));
      step();
    end
    r0 = ret_cnt;
    respond(s[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_burst", 64'(core_resp_valid), 64'(1));
      step();
    end
    @(negedge clk);
    chk("t2_empty", 64'(core_resp_valid), 64'(0));
    chk("t2_count", 64'(ret_cnt), 64'(r0 + 4));
    step();

    // 3: full blocks issue; a retire frees a slot only on the following cycle
    for (int i = 0; i < N; i++) issue(meta_id_t'(i), 1'b1, sl);
    set_req(4'd15, 1'b0);
    core_req_valid = 1'b1;
    @(negedge clk);
    chk("t3_full_ready", 64'(core_req_ready), 64'(0));
    chk("t3_full_mvalid", 64'(mem_req_valid), 64'(0));
    step();
    core_req_valid = 1'b0;
    respond(pend_q[0]);
    @(negedge clk);
    chk("t3_retire", 64'(core_resp_valid), 64'(1));
    chk("t3_same_cycle", 64'(core_req_ready), 64'(0));
    step();
    @(negedge clk);
    chk("t3_rise", 64'(core_req_ready), 64'(1));
    step();
    while (pend_q.size() > 0) respond(pend_q[0]);
    drain("t3");

    // 4: twelve requests, random response order, tags wrap at N-1
    begin
      int base = n_issued;
      guard = 0;
      while ((n_issued - base < 12 || pend_q.size() > 0) && guard < 500) begin
        if (n_issued - base < 12 && (n_issued - ret_cnt) < N && $urandom_range(0, 1) == 1)
          issue(meta_id_t'(n_issued - base), 1'((n_issued - base) % 2), sl);
        else if (pend_q.size() > 0) respond(pend_q[$urandom_range(0, pend_q.size() - 1)]);
        else step();
        guard++;
      end
      chk("t4_issued", 64'(n_issued - base), 64'(12));
    end
    drain("t4");

    // 5: backpressure holds payload stable while issue fills the buffer
    core_resp_ready = 1'b0;
    issue(4'd1, 1'b0, sl);
    respond(sl);
    for (int c = 0; c < 10; c++) begin
      set_req(meta_id_t'(c), 1'b1);
      core_req_valid = ((n_issued - ret_cnt) < N);
      @(negedge clk);
      chk("t5_valid", 64'(core_resp_valid), 64'(1));
      chk("t5_payload", 64'(core_resp), 64'(exp_q[0]));
      if (core_req_valid) begin
        chk("t5_ready", 64'(core_req_ready), 64'(1));
        if (core_req_ready) accept_record("t5");
      end
      step();
    end
    core_req_valid = 1'b0;
    @(negedge clk);
    chk("t5_full", 64'(core_req_ready), 64'(0));
    step();
    core_resp_ready = 1'b1;
    while (pend_q.size() > 0) respond(pend_q[0]);
    drain("t5");

    // 6: reset with outstanding entries, then a stale response is dropped
    core_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(meta_id_t'(12 + i), 1'b0, sl);
    respond(pend_q[0]);
    @(negedge clk);
    chk("t6_pre_valid", 64'(core_resp_valid), 64'(1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
    exp_tail = 0;
    n_issued = 0;
    ret_cnt  = 0;
    @(negedge clk);
    chk("t6_valid", 64'(core_resp_valid), 64'(0));
    chk("t6_ready", 64'(core_req_ready), 64'(1));
    chk("t6_tail", 64'(mem_req.id), 64'(0));
    step();
    core_resp_ready = 1'b1;
    respond(1);
    @(negedge clk);
    chk("t6_stale", 64'(core_resp_valid), 64'(0));
    step();
    issue(4'd3, 1'b0, sl);
    respond(sl);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
